// File: rtl/enigma_return_path.sv
`timescale 1ns/1ps
// enigma_return_path
//
// Return (reflector-to-plugboard) half of an Enigma scrambler: a letter that
// has come back from the reflector is passed backward through the inverse
// wiring of the left (rotor I), middle (rotor II) and right (rotor III)
// rotors, one rotor per pipeline stage, with a valid/ready handshake on
// both sides. Ring settings are fixed at 0.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   data_in and rotor positions are present
//   in_ready   block accepts the input this cycle
//   data_in    letter code from the reflector, 0=A .. 25=Z
//   pos_l      left rotor offset, 0..25
//   pos_m      middle rotor offset, 0..25
//   pos_r      right rotor offset, 0..25
//   out_valid  result present
//   out_ready  downstream accepts the result
//   data_out   ciphertext letter 0..25, or 31 for a flagged letter
//   err        letter or a position was out of range (qualified by out_valid)

module enigma_return_path (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] data_in,
  input  logic [4:0] pos_l,
  input  logic [4:0] pos_m,
  input  logic [4:0] pos_r,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] data_out,
  output logic       err
);

  // Inverse wirings: entry k is the letter that k maps to on the way back.
  localparam logic [4:0] INV_I [26] = '{
    5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25,
    5'd1,  5'd4,  5'd2,  5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11,
    5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9};
  localparam logic [4:0] INV_II [26] = '{
    5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,
    5'd3,  5'd10, 5'd14, 5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13,
    5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18};
  localparam logic [4:0] INV_III [26] = '{
    5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,
    5'd20, 5'd5,  5'd21, 5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,
    5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};

  // Reduce a 6-bit value (0..63) into 0..25. Two conditional subtractions
  // cover the whole 6-bit range, so even garbage from an out-of-range letter
  // or position still indexes the tables safely.
  function automatic logic [4:0] mod26(input logic [5:0] v);
    if (v >= 6'd52)
      return 5'(v - 6'd52);
    else if (v >= 6'd26)
      return 5'(v - 6'd26);
    else
      return 5'(v);
  endfunction

  // Pipeline stage registers. Each stage keeps only the positions that the
  // later rotors still need.
  logic       s1_valid, s1_err;
  logic [4:0] s1_letter, s1_pos_m, s1_pos_r;
  logic       s2_valid, s2_err;
  logic [4:0] s2_letter, s2_pos_r;
  logic       s3_valid, s3_err;
  logic [4:0] s3_letter;

  // Handshake chain: a stage may load when it is empty or its contents
  // move on in the same cycle. Depends only on state and out_ready.
  logic ready1, ready2, ready3;
  assign ready3 = !s3_valid || out_ready;
  assign ready2 = !s2_valid || ready3;
  assign ready1 = !s1_valid || ready2;

  // Gated by rst so the block reports not-ready while held in reset.
  assign in_ready = rst && ready1;

  logic in_err;
  assign in_err = (data_in > 5'd25) || (pos_l > 5'd25) ||
                  (pos_m > 5'd25) || (pos_r > 5'd25);

  // Per-stage rotor arithmetic: y = (INV[(x + p) mod 26] - p) mod 26.
  // Adding 26 before subtracting p keeps the difference non-negative.
  logic [4:0] s1_next, s2_next, s3_next;
  logic [4:0] inv1, inv2, inv3;
  assign inv1    = INV_I[mod26({1'b0, data_in} + {1'b0, pos_l})];
  assign s1_next = mod26({1'b0, inv1} + 6'd26 - {1'b0, pos_l});
  assign inv2    = INV_II[mod26({1'b0, s1_letter} + {1'b0, s1_pos_m})];
  assign s2_next = mod26({1'b0, inv2} + 6'd26 - {1'b0, s1_pos_m});
  assign inv3    = INV_III[mod26({1'b0, s2_letter} + {1'b0, s2_pos_r})];
  assign s3_next = mod26({1'b0, inv3} + 6'd26 - {1'b0, s2_pos_r});

  // Stage 1: capture the letter through rotor I along with the positions
  // the later stages need, so later position changes cannot touch it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_err    <= 1'b0;
      s1_letter <= 5'd0;
      s1_pos_m  <= 5'd0;
      s1_pos_r  <= 5'd0;
    end else if (ready1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_err    <= in_err;
        s1_letter <= s1_next;
        s1_pos_m  <= pos_m;
        s1_pos_r  <= pos_r;
      end
    end
  end

  // Stage 2: rotor II.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid  <= 1'b0;
      s2_err    <= 1'b0;
      s2_letter <= 5'd0;
      s2_pos_r  <= 5'd0;
    end else if (ready2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_err    <= s1_err;
        s2_letter <= s2_next;
        s2_pos_r  <= s1_pos_r;
      end
    end
  end

  // Stage 3: rotor III; this register is the output and holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_valid  <= 1'b0;
      s3_err    <= 1'b0;
      s3_letter <= 5'd0;
    end else if (ready3) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_err    <= s2_err;
        s3_letter <= s3_next;
      end
    end
  end

  // Outputs read as zero when nothing is presented; flagged letters show 31.
  assign out_valid = s3_valid;
  assign err       = s3_valid && s3_err;
  assign data_out  = !s3_valid ? 5'd0 : (s3_err ? 5'd31 : s3_letter);

endmodule

// File: tb/tb_enigma_return_path.sv
`timescale 1ns/1ps
// tb_enigma_return_path
//
// Directed bench for enigma_return_path. Expected ciphertext values are
// worked out by hand from the inverse rotor wirings.

module tb_enigma_return_path;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] data_in;
  logic [4:0] pos_l, pos_m, pos_r;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] data_out;
  logic       err;

  int compared_cnt = 0;
  int mismatch_cnt = 0;

  always #5 clk = ~clk;

  enigma_return_path dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .pos_l     (pos_l),
    .pos_m     (pos_m),
    .pos_r     (pos_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err       (err)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compared_cnt++;
    if (got !== exp) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] d, input logic [4:0] pl,
                               input logic [4:0] pm, input logic [4:0] pr);
    in_valid = 1'b1;
    data_in  = d;
    pos_l    = pl;
    pos_m    = pm;
    pos_r    = pr;
  endtask

  // One letter in, checking the exact 3-cycle latency and the drain. After
  // acceptance the positions are scrambled to show they were captured.
  task automatic run_single(input string tag, input logic [4:0] d,
                            input logic [4:0] pl, input logic [4:0] pm,
                            input logic [4:0] pr, input logic [4:0] exp_data,
                            input logic exp_err);
    applyStimulus(d, pl, pm, pr);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    data_in  = 5'd0;
    pos_l    = 5'd7;
    pos_m    = 5'd13;
    pos_r    = 5'd19;
    checkOutput({tag, "_cyc1_valid"}, out_valid, 0);
    tick();
    checkOutput({tag, "_cyc2_valid"}, out_valid, 0);
    tick();
    checkOutput({tag, "_cyc3_valid"}, out_valid, 1);
    checkOutput({tag, "_data"}, data_out, exp_data);
    checkOutput({tag, "_err"}, err, exp_err);
    tick();
    checkOutput({tag, "_drain_valid"}, out_valid, 0);
    checkOutput({tag, "_drain_data"}, data_out, 0);
    pos_l = 5'd0;
    pos_m = 5'd0;
    pos_r = 5'd0;
  endtask

  initial begin
    int sent;
    int got_n;
    int stale;
    logic acc;
    int got [5];
    int exp_stream [5];
    exp_stream = '{3, 21, 11, 8, 19};

    rst       = 1'b0;
    in_valid  = 1'b0;
    data_in   = 5'd0;
    pos_l     = 5'd0;
    pos_m     = 5'd0;
    pos_r     = 5'd0;
    out_ready = 1'b1;

    // Reset state.
    #12;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_data_out", data_out, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("post_reset_in_ready", in_ready, 1);

    // Basic letter, positions 0/0/0: A -> D.
    run_single("basic", 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 1'b0);

    // Back-to-back A, B -> D, V on consecutive cycles.
    applyStimulus(5'd0, 5'd0, 5'd0, 5'd0);
    tick();
    applyStimulus(5'd1, 5'd0, 5'd0, 5'd0);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("b2b_first_valid", out_valid, 1);
    checkOutput("b2b_first_data", data_out, 3);
    tick();
    checkOutput("b2b_second_valid", out_valid, 1);
    checkOutput("b2b_second_data", data_out, 21);
    tick();
    checkOutput("b2b_empty", out_valid, 0);

    // Left rotor offset, including the wrap at 25.
    run_single("posl1", 5'd0, 5'd1, 5'd0, 5'd0, 5'd10, 1'b0);
    run_single("posl25", 5'd1, 5'd25, 5'd0, 5'd0, 5'd10, 1'b0);

    // Backpressure: stream 5 letters with out_ready low.
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      if (sent < 5) applyStimulus(5'(sent), 5'd0, 5'd0, 5'd0);
      else in_valid = 1'b0;
      #1;
      acc = in_ready;
      tick();
      if (acc) sent++;
    end
    checkOutput("stall_accepted", sent, 3);
    checkOutput("stall_in_ready", in_ready, 0);
    checkOutput("stall_head_valid", out_valid, 1);
    checkOutput("stall_head_data", data_out, 3);
    tick();
    checkOutput("stall_hold_valid", out_valid, 1);
    checkOutput("stall_hold_data", data_out, 3);

    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", in_ready, 1);
    got_n = 0;
    for (int i = 0; i < 5; i++) got[i] = -1;
    for (int c = 0; c < 20 && got_n < 5; c++) begin
      if (sent < 5) applyStimulus(5'(sent), 5'd0, 5'd0, 5'd0);
      else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        got[got_n] = int'(data_out);
        got_n++;
      end
      acc = in_ready;
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    checkOutput("release_count", got_n, 5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("release_order_%0d", i), got[i], exp_stream[i]);
    checkOutput("release_no_extra", out_valid, 0);

    // Out-of-range letter and position.
    run_single("err_data", 5'd27, 5'd0, 5'd0, 5'd0, 5'd31, 1'b1);
    run_single("err_posm", 5'd0, 5'd0, 5'd26, 5'd0, 5'd31, 1'b1);

    // Reset with two letters in flight, one already presented.
    applyStimulus(5'd2, 5'd0, 5'd0, 5'd0);
    tick();
    applyStimulus(5'd4, 5'd0, 5'd0, 5'd0);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("pre_reset_valid", out_valid, 1);
    checkOutput("pre_reset_data", data_out, 11);
    rst = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_data_out", data_out, 0);
    checkOutput("midreset_in_ready", in_ready, 0);
    tick();
    rst = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) stale++;
    end
    checkOutput("no_stale_output", stale, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared_cnt, mismatch_cnt);
    $finish;
  end

endmodule

// File: doc/enigma_return_path.md
ENIGMA_RETURN_PATH -- requirements
Module: enigma_return_path

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  reflected letter and rotor positions present.
REQ-004 SHALL have port: in_ready  output  1  block accepts the input this cycle.
REQ-005 SHALL have port: data_in  input  5  letter code from the reflector, 0=A..25=Z.
REQ-006 SHALL have port: pos_l, pos_m, pos_r  input  5 each  left, middle and right rotor offsets, 0..25.
REQ-007 SHALL have port: out_valid  output  1  result present.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts the result.
REQ-009 SHALL have port: data_out  output  5  ciphertext letter code, 0..25, or 31 on error.
REQ-010 SHALL have port: err  output  1  input code or position out of range, qualified by out_valid.

Function
REQ-011 SHALL pass each letter backward through three inverse rotors in this order: left (rotor I), middle (rotor II), right (rotor III). Ring setting is fixed at 0.
REQ-012 SHALL use these inverse wirings, where the letter at index k is the image of k:
- I = UWYGADFPVZBECKMTHXSLRINQOJ
- II = AJPCZWRLFBDKOTYUQGENHXMIVS
- III = TAGBPCSDQEUFVNZHYIXJWLRKOM
REQ-013 SHALL compute each stage as y = (INV[(x + p) mod 26] - p) mod 26, where p is that rotor's captured position. Intermediate sums SHALL use at least 6 bits, and every result SHALL be in 0..25.
REQ-014 SHALL be a 3-stage pipeline with one inverse rotor per stage. Each stage SHALL hold a valid bit, the letter, an err bit and the positions still needed downstream.
REQ-015 SHALL capture pos_l/pos_m/pos_r together with data_in on acceptance. Later changes to the position inputs SHALL NOT affect letters already in flight.
REQ-016 SHALL accept an input when in_valid && in_ready, and deliver a result when out_valid && out_ready.
REQ-017 SHALL have a latency of exactly 3 cycles from acceptance to out_valid when out_ready is held high.
REQ-018 SHALL sustain one accepted input per cycle when out_ready=1.
REQ-019 SHALL advance stage n when stage n is empty or stage n+1 advances in the same cycle, so in_ready = !s1_valid || s1 advances. in_ready SHALL NOT depend combinationally on in_valid.
REQ-020 SHALL hold out_valid, data_out and err stable while out_valid && !out_ready. No data SHALL be lost or duplicated, and no more than 3 letters SHALL be in flight.
REQ-021 SHALL drive in_ready=0 when all stages are full and out_ready=0. When out_ready rises, it SHALL allow acceptance in that same cycle.
REQ-022 SHALL flag an error when data_in > 25 or any position > 25 at acceptance. Such a letter SHALL propagate with err=1, emerge with data_out=31 and occupy the normal slot and latency.
REQ-023 SHALL drive data_out=0 and err=0 whenever out_valid=0.

Reset
REQ-024 SHALL, while rst=0, asynchronously clear all stage valid bits, letters, err bits and positions to 0.
REQ-025 SHALL present out_valid=0, data_out=0, err=0 and in_ready=0 during reset, with in_ready=1 in the first cycle after rst deasserts.
REQ-026 SHALL discard any in-flight letters when reset asserts mid-operation; no partial result SHALL emerge after release.

Verification
REQ-027 SHALL be covered by a bench running these scenarios:
- Positions 0/0/0, data_in=0, out_ready=1 -> data_out=3, err=0, out_valid exactly 3 cycles after acceptance.
- Positions 0/0/0, back-to-back data_in=0,1 on consecutive cycles -> outputs 3 then 21 on consecutive cycles.
- pos_l=1, others 0, data_in=0 -> data_out=10; pos_l=25, data_in=1 (wrap) -> data_out=10.
- out_ready=0 while streaming 5 letters -> in_ready=0 after 3 accepted, head output held stable; release -> all 5 emerge in order, none lost.
- data_in=27 -> err=1, data_out=31 after 3 cycles; pos_m=26 -> same.
- rst=0 asserted with 2 letters in flight -> out_valid=0 immediately; after release, no stale output appears.
